// File: rtl/spram_fifo_pkg.sv
// Shared types and constants for the SPRAM-backed byte FIFO.
// Grant encoding, default address width and the memory-port arbiter rule.
package spram_fifo_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_t;

  // 128KB bank addressed per byte
  localparam int SPRAM_ADDR_W = 17;
  localparam int DATA_W       = 8;

  // One grant per cycle: a lone requester wins, contention alternates
  // against whichever side won the last real grant.
  function automatic gnt_t arb_pick(input logic wr_want,
                                    input logic rd_want,
                                    input gnt_t last_gnt);
    gnt_t g;
    g = GNT_NONE;
    if (wr_want && rd_want)
      g = (last_gnt == GNT_WR) ? GNT_RD : GNT_WR;
    else if (wr_want)
      g = GNT_WR;
    else if (rd_want)
      g = GNT_RD;
    return g;
  endfunction

endpackage

// File: rtl/spram_fifo_outbuf.sv
// Two-entry first-word-fall-through buffer holding bytes returned by SPRAM
// reads until the downstream consumer takes them. Push and pop may coincide;
// the caller guarantees a push never lands on a full buffer.
module spram_fifo_outbuf
  import spram_fifo_pkg::*;
#(
  parameter int DATA_W_OB = DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_push,
  input  logic [DATA_W_OB-1:0] i_push_data,
  input  logic                 i_pop,
  output logic [DATA_W_OB-1:0] o_head,
  output logic [1:0]           o_cnt
);

  logic [DATA_W_OB-1:0] r_data [2];
  logic                 r_wr_idx;
  logic                 r_rd_idx;
  logic [1:0]           r_cnt;
  logic                 w_pop;

  // A pop on an empty buffer is ignored
  assign w_pop = i_pop && (r_cnt != 2'd0);

  // Control: slot indices and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (i_clear) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) r_wr_idx <= ~r_wr_idx;
      if (w_pop)  r_rd_idx <= ~r_rd_idx;
      case ({i_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Data storage: no reset needed, occupancy says what is meaningful
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_data[r_wr_idx] <= i_push_data;
  end

  assign o_head = r_data[r_rd_idx];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/spram_byte_fifo.sv
// Deep byte FIFO built on a single-port byte-wide SPRAM bank.
// Input bytes are written at a wrapping write pointer, read back in order
// at a wrapping read pointer, and staged in a 2-entry FWFT output buffer.
// One memory access per cycle; read data returns one cycle after issue.
// Optional feature: define SPRAM_FIFO_WATERMARK_EN to add the registered
// almost_full output (level >= AFULL_THRESH) and its AFULL_THRESH parameter.
module spram_byte_fifo
  import spram_fifo_pkg::*;
#(
  parameter int ADDR_W = SPRAM_ADDR_W
`ifdef SPRAM_FIFO_WATERMARK_EN
  ,
  parameter int AFULL_THRESH = 2**ADDR_W - 256
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W:0]   level,
`ifdef SPRAM_FIFO_WATERMARK_EN
  output logic              almost_full,
`endif
  output logic              mem_cs,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  input  logic [7:0]        mem_rd_data
);

  // Bank capacity in bytes, expressed in the count width
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_mem_count;
  logic [ADDR_W:0]   r_level;
  logic [ADDR_W:0]   w_level_nxt;
  logic              r_rd_vld_p1;
  gnt_t              r_last_gnt;
  gnt_t              w_gnt;

  logic              w_full;
  logic              w_wr_want;
  logic              w_rd_want;
  logic [2:0]        w_occ;
  logic [1:0]        w_ob_cnt;
  logic [7:0]        w_ob_head;
  logic              w_accept;
  logic              w_pop;
  logic              w_push_p1;

  assign w_full    = (r_mem_count == DEPTH);
  assign w_wr_want = s_valid && !w_full;
  // Bytes already committed to the output side: buffered plus in flight
  assign w_occ     = {1'b0, w_ob_cnt} + {2'b00, r_rd_vld_p1};
  assign w_rd_want = (r_mem_count != '0) && (w_occ < 3'd2);

  // Arbiter: one memory grant per cycle, suppressed during reset and flush
  always_comb begin
    w_gnt = GNT_NONE;
    if (!rst && !flush)
      w_gnt = arb_pick(w_wr_want, w_rd_want, r_last_gnt);
  end

  // Memory port and stream handshakes follow the grant directly
  always_comb begin
    mem_cs      = (w_gnt != GNT_NONE);
    mem_wr_en   = (w_gnt == GNT_WR);
    mem_addr    = (w_gnt == GNT_WR) ? r_wr_ptr : r_rd_ptr;
    mem_wr_data = s_data;
    s_ready     = (w_gnt == GNT_WR);
    m_valid     = (w_ob_cnt != 2'd0);
    m_data      = w_ob_head;
  end

  assign w_accept  = s_valid && s_ready;
  assign w_pop     = m_valid && m_ready && !flush;
  assign w_push_p1 = r_rd_vld_p1 && !flush;

  // Pointers, SPRAM occupancy, read-in-flight flag and arbitration history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_last_gnt  <= GNT_RD;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_count <= '0;
      r_rd_vld_p1 <= 1'b0;
      r_last_gnt  <= GNT_RD;
    end else begin
      r_rd_vld_p1 <= (w_gnt == GNT_RD);
      case (w_gnt)
        GNT_WR: begin
          r_wr_ptr    <= r_wr_ptr + 1'b1;
          r_mem_count <= r_mem_count + 1'b1;
          r_last_gnt  <= GNT_WR;
        end
        GNT_RD: begin
          r_rd_ptr    <= r_rd_ptr + 1'b1;
          r_mem_count <= r_mem_count - 1'b1;
          r_last_gnt  <= GNT_RD;
        end
        default: ;
      endcase
    end
  end

  // Next level: +1 per accepted byte, -1 per consumed byte
  always_comb begin
    w_level_nxt = r_level;
    if (flush)
      w_level_nxt = '0;
    else begin
      case ({w_accept, w_pop})
        2'b10:   w_level_nxt = r_level + 1'b1;
        2'b01:   w_level_nxt = r_level - 1'b1;
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Registered total fill level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_level <= '0;
    else     r_level <= w_level_nxt;
  end

  assign level = r_level;

`ifdef SPRAM_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] AFULL_C = AFULL_THRESH[ADDR_W:0];
  logic r_afull;

  // Watermark tracks the level register it is compared against
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_afull <= 1'b0;
    else     r_afull <= (w_level_nxt >= AFULL_C);
  end

  assign almost_full = r_afull;
`endif

  // Read data lands in the output buffer one cycle after the read issues
  spram_fifo_outbuf #(
    .DATA_W_OB (8)
  ) u_outbuf (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (flush),
    .i_push      (w_push_p1),
    .i_push_data (mem_rd_data),
    .i_pop       (w_pop),
    .o_head      (w_ob_head),
    .o_cnt       (w_ob_cnt)
  );

endmodule

// File: tb/tb_spram_byte_fifo.sv
// Self-checking bench for spram_byte_fifo with a small SPRAM model.
// The reference is a byte queue: accepted bytes append, consumed bytes must
// match the head, and level must equal the queue size. Memory addresses are
// checked against running write/read counts modulo the bank depth.
module tb_spram_byte_fifo;

  localparam int AW    = 5;
  localparam int DEPTH = 2**AW;
  localparam int THR   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW:0]   level;
  logic          mem_cs;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [7:0]    mem_wr_data;
  logic [7:0]    mem_rd_data = 8'h00;
`ifdef SPRAM_FIFO_WATERMARK_EN
  logic          almost_full;
`endif

  spram_byte_fifo #(
    .ADDR_W       (AW)
`ifdef SPRAM_FIFO_WATERMARK_EN
    ,
    .AFULL_THRESH (THR)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .level       (level),
`ifdef SPRAM_FIFO_WATERMARK_EN
    .almost_full (almost_full),
`endif
    .mem_cs      (mem_cs),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  // SPRAM bank model: write at the issue edge, read data valid next cycle
  logic [7:0] mem_model [DEPTH];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_wr_en) mem_model[mem_addr] <= mem_wr_data;
      else           mem_rd_data <= mem_model[mem_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  int exp_wa = 0;
  int exp_ra = 0;
  int n_pop  = 0;
  int n_acc  = 0;
  logic last_acc = 1'b0;
  logic last_rd  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    exp_wa = 0;
    exp_ra = 0;
  endtask

  // One clock cycle: drive, evaluate handshakes against the model, clock, check level
  task automatic cycle(input logic sv, input logic [7:0] sd, input logic mr, input logic fl);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    #1;
    last_acc = s_valid && s_ready;
    last_rd  = mem_cs && !mem_wr_en;
    if (fl) begin
      chk("flush_s_ready", 32'(s_ready), 0);
      chk("flush_mem_cs", 32'(mem_cs), 0);
      model_clear();
    end else begin
      chk("s_ready_is_wr", 32'(s_ready), 32'(mem_cs && mem_wr_en));
      if (mem_cs && mem_wr_en) begin
        chk("wr_addr", 32'(mem_addr), 32'(exp_wa % DEPTH));
        chk("wr_data", 32'(mem_wr_data), 32'(sd));
      end
      if (mem_cs && !mem_wr_en) begin
        chk("rd_addr", 32'(mem_addr), 32'(exp_ra % DEPTH));
        exp_ra++;
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) chk("m_valid_spurious", 32'(m_valid), 0);
        else begin
          chk("m_data", 32'(m_data), 32'(q[0]));
          void'(q.pop_front());
        end
        n_pop++;
      end
      if (s_valid && s_ready) begin
        q.push_back(sd);
        exp_wa++;
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
    chk("level", 32'(level), 32'(q.size()));
`ifdef SPRAM_FIFO_WATERMARK_EN
    chk("almost_full", 32'(almost_full), 32'(q.size() >= THR));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] seq;
    // Power-on reset state
    s_valid = 1'b1;
    #12;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_mem_cs", 32'(mem_cs), 0);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_level", 32'(level), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_s_ready", 32'(s_ready), 1);
    model_clear();

    // Reset asserted in the middle of random traffic
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 0);
    chk("midrst_mem_cs", 32'(mem_cs), 0);
    chk("midrst_s_ready", 32'(s_ready), 0);
    chk("midrst_level", 32'(level), 0);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    rst = 1'b0;
    model_clear();
    #1;
    chk("midrst_rel_s_ready", 32'(s_ready), 1);
    chk("midrst_rel_m_valid", 32'(m_valid), 0);

    // 16 counting bytes held back, then drained in order
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    n_acc = 0;
    for (int i = 0; i < 60 && n_acc < 16; i++)
      cycle(1'b1, 8'(n_acc), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("burst16_level", 32'(level), 16);
    chk("burst16_m_valid", 32'(m_valid), 1);
    chk("burst16_head", 32'(m_data), 32'h00);
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("burst16_drained", 32'(level), 0);

    // Simultaneous streaming: memory grants alternate write/read
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    seq = 8'h00;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, seq, 1'b1, 1'b0);
      chk("alt_wr_grant", 32'(last_acc), 32'((i % 2) == 0));
      if (last_acc) seq = seq + 8'h01;
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_drained", 32'(level), 0);

    // Fill until the bank and output buffer are both full
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2 * DEPTH + 20; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("full_level", 32'(level), 32'(DEPTH + 2));
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_mem_cs", 32'(mem_cs), 0);

    // Drain some, refill across the pointer wrap, drain everything
    n_pop = 0;
    for (int i = 0; i < 60 && n_pop < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 60 && n_acc < 10; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("wrap_refill_acc", 32'(n_acc), 10);
    chk("wrap_level", 32'(level), 32'(DEPTH + 2));
    for (int i = 0; i < 4 * DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("wrap_drained", 32'(level), 0);

    // Flush while a read is in flight and the output buffer is occupied
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 2 * DEPTH + 20; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("pre_flush_rd_issue", 32'(last_rd), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_m_valid", 32'(m_valid), 0);
    chk("flush_level", 32'(level), 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("flush_discard", 32'(m_valid), 0);
    end

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 3;
      cycle(1'($urandom_range(0, 3) <= dens + 1),
            8'($urandom),
            1'($urandom_range(0, 3) >= dens),
            1'($urandom_range(0, 299) == 0));
    end
    for (int i = 0; i < 4 * DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("final_level", 32'(level), 0);
    chk("final_m_valid", 32'(m_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
